dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory subsystem attached to the single-cycle MIPS core's data port: consumes `memwrite`, `aluout` (as address) and `writedata`, and returns `readdata` in the same cycle. It decodes each access to a word-addressed data RAM or a small memory-mapped register bank, which holds a GPIO output register and a compare-match timer that raises an interrupt line.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; power of two, minimum 4.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  store strobe from the core.
- `addr`  in  32  byte address (core `aluout`).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational from `addr` and current state.
- `gpio`  out  32  GPIO_OUT register value.
- `irq`  out  1  timer interrupt, level.

## Operation
- Decode: `addr[31:16] == 16'hFFFF` selects MMIO. Otherwise RAM, index `addr[$clog2(RAM_WORDS)+1:2]`; upper bits ignored, so RAM aliases modulo size. `addr[1:0]` ignored everywhere; word accesses only.
- RAM: write on edge when `memwrite` and RAM selected. Contents are not reset.
- MMIO map, offset `addr[7:0]`:
  - 0x00 GPIO_OUT, rw, 32 bits, drives `gpio`.
  - 0x04 TMR_CTRL, rw: bit0 EN, bit1 RELOAD, bit2 IRQEN; other bits read 0.
  - 0x08 TMR_COUNT, rw.
  - 0x0C TMR_CMP, rw.
  - 0x10 TMR_STAT: bit0 MATCH; write 1 clears, write 0 has no effect.
  - Other offsets read 0; writes ignored. `addr[15:8]` not decoded, so MMIO aliases every 256 bytes.
- Timer, evaluated each cycle on registered values:
  - `match = EN && COUNT == CMP`.
  - EN=1, no match: COUNT <= COUNT+1, wrapping 0xFFFFFFFF to 0.
  - Match with RELOAD=1: COUNT <= 0; EN stays 1 (periodic).
  - Match with RELOAD=0: COUNT holds; EN <= 0 (one-shot).
  - Any match sets MATCH at the next edge.
  - EN=0: COUNT holds.
- `irq = MATCH & IRQEN`, driven from registers only; no combinational path from inputs.
- Simultaneous events:
  - A software write to TMR_COUNT beats both the increment and the reload.
  - A software write to TMR_CTRL beats the one-shot EN clear.
  - In the same cycle, match-set beats W1C-clear: MATCH ends at 1.
- Reset: GPIO_OUT, CTRL, COUNT, CMP and MATCH all go to 0. `gpio` = 0 and `irq` = 0 in the cycle after reset is sampled. `readdata` of MMIO registers reads 0. RAM is undefined until written.

## Timing
- Loads: zero latency. `readdata` is valid in the same cycle as `addr`, as required by the single-cycle datapath.
- Stores: take effect at the edge ending the `memwrite` cycle. A read of the same location in the next cycle returns the new value.
- Timer: EN written 1 at edge T with COUNT=0, CMP=N. COUNT equals k during cycle T+1+k. Match occurs in cycle T+1+N; MATCH and `irq` go high at edge T+2+N.
- `reset` is held for at least one edge; a reset in mid-count or mid-match discards all timer state at that edge.

## Configuration
- `DMEM_TIMER_EN` defined: timer registers, counter logic and `irq` are implemented as above.
- `DMEM_TIMER_EN` undefined: offsets 0x04–0x10 read 0 and ignore writes; `irq` is tied to 0; no counter flops. RAM and GPIO_OUT are unchanged.

## Test plan
- RAM write/read: store 0xDEADBEEF at 0x0000_0010, then load 0x0000_0010 → 0xDEADBEEF. Load alias 0x0000_0110 (RAM_WORDS=64) → 0xDEADBEEF.
- GPIO: store 0x0000_00A5 to 0xFFFF_0000 → `gpio` = 0x0000_00A5 next cycle; load 0xFFFF_0000 → 0xA5. Load 0xFFFF_0020 → 0.
- Periodic timer: CMP=3, CTRL=0b111 → COUNT sequence 0,1,2,3,0,1,…; `irq` rises one cycle after COUNT=3. Storing 1 to 0xFFFF_0010 drops `irq` next cycle, and it re-asserts on the next match.
- One-shot plus simultaneous events: CMP=2, CTRL=0b101 → COUNT holds at 2, CTRL reads 0b100, `irq`=1. A W1C in the exact match cycle of a periodic run leaves MATCH=1.
- Wrap and override: COUNT=0xFFFF_FFFF, CMP=5, EN=1 → next COUNT=0. A write of COUNT=7 in a cycle where the increment is pending → COUNT reads 7.
- Reset mid-operation: assert `reset` while the timer is running with `irq`=1 → next cycle `irq`=0, `gpio`=0, all MMIO loads return 0.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle MIPS core: word RAM plus an MMIO bank (GPIO_OUT, compare-match timer).
// Loads are combinational and stores commit on the clock edge; the timer exists only when DMEM_TIMER_EN is defined.
module dmem_mmio #(
  parameter int RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] gpio,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic          mmio_sel;
  logic [AW-1:0] ram_idx;
  logic [7:0]    off;
  logic          mmio_wr;
  logic          unused_addr;

  assign mmio_sel    = (addr[31:16] == 16'hFFFF);
  assign ram_idx     = addr[AW+1:2];
  assign off         = addr[7:0];
  assign mmio_wr     = memwrite && mmio_sel;
  assign unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (memwrite && !mmio_sel) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset)                         gpio <= '0;
    else if (mmio_wr && off == 8'h00)  gpio <= writedata;
  end

`ifdef DMEM_TIMER_EN
  logic [2:0]  ctrl;   // {IRQEN, RELOAD, EN}
  logic [31:0] count;
  logic [31:0] cmp;
  logic        match_flag;
  logic        tmr_match;

  assign tmr_match = ctrl[0] && (count == cmp);

  // Software writes take priority over the timer's own updates, except that
  // a new match always sets MATCH even if the same cycle clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl       <= '0;
      count      <= '0;
      cmp        <= '0;
      match_flag <= 1'b0;
    end else begin
      if (mmio_wr && off == 8'h04)   ctrl    <= writedata[2:0];
      else if (tmr_match && !ctrl[1]) ctrl[0] <= 1'b0;

      if (mmio_wr && off == 8'h08)   count <= writedata;
      else if (tmr_match && ctrl[1]) count <= '0;
      else if (ctrl[0] && !tmr_match) count <= count + 32'd1;

      if (mmio_wr && off == 8'h0C) cmp <= writedata;

      if (tmr_match)                                         match_flag <= 1'b1;
      else if (mmio_wr && off == 8'h10 && writedata[0])      match_flag <= 1'b0;
    end
  end

  assign irq = match_flag & ctrl[2];
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    if (!mmio_sel) begin
      readdata = ram[ram_idx];
    end else begin
      case (off)
        8'h00:   readdata = gpio;
`ifdef DMEM_TIMER_EN
        8'h04:   readdata = {29'd0, ctrl};
        8'h08:   readdata = count;
        8'h0C:   readdata = cmp;
        8'h10:   readdata = {31'd0, match_flag};
`endif
        default: readdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: scoreboard queue of expected values, compared by immediate assertions.
module tb_dmem_mmio;
  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] gpio;
  logic        irq;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] GPIO_A = 32'hFFFF_0000;
  localparam logic [31:0] CTRL_A = 32'hFFFF_0004;
  localparam logic [31:0] CNT_A  = 32'hFFFF_0008;
  localparam logic [31:0] CMP_A  = 32'hFFFF_000C;
  localparam logic [31:0] STAT_A = 32'hFFFF_0010;

  dmem_mmio #(.RAM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .gpio(gpio), .irq(irq)
  );

  always #10 clk = ~clk;

  task automatic push_exp(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic compare(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    addr = a;
    push_exp(e);
    #1;
    compare(tag, readdata);
  endtask

  task automatic check_gpio(input string tag, input logic [31:0] e);
    push_exp(e);
    #1;
    compare(tag, gpio);
  endtask

  task automatic check_irq(input string tag, input logic e);
    push_exp({31'd0, e});
    #1;
    compare(tag, {31'd0, irq});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    @(posedge clk);
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; addr = '0; writedata = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check_gpio("rst_gpio", 32'h0);
    check_irq("rst_irq", 1'b0);
    check_rd("rst_gpio_rd", GPIO_A, 32'h0);
    check_rd("rst_ctrl_rd", CTRL_A, 32'h0);
    check_rd("rst_stat_rd", STAT_A, 32'h0);

    // RAM and aliasing
    store(32'h0000_0010, 32'hDEAD_BEEF);
    check_rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    check_rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    check_rd("ram_bytesel_ignored", 32'h0000_0013, 32'hDEAD_BEEF);
    store(32'h0000_0000, 32'h1111_1111);
    store(32'hFFFE_00FC, 32'h2222_2222);
    check_rd("ram_near_mmio", 32'h0000_00FC, 32'h2222_2222);

    // GPIO
    store(GPIO_A, 32'h0000_00A5);
    check_gpio("gpio_out", 32'h0000_00A5);
    check_rd("gpio_rd", GPIO_A, 32'h0000_00A5);
    check_rd("gpio_alias", 32'hFFFF_0100, 32'h0000_00A5);
    check_rd("unmapped_rd", 32'hFFFF_0020, 32'h0);
    check_rd("ram_untouched_by_mmio", 32'h0000_0000, 32'h1111_1111);
    store(32'h0000_0000, 32'h3333_3333);
    check_gpio("gpio_untouched_by_ram", 32'h0000_00A5);
    store(32'hFFFF_0020, 32'h5A5A_5A5A);
    check_gpio("gpio_untouched_by_unmapped", 32'h0000_00A5);

`ifdef DMEM_TIMER_EN
    // Periodic timer: CMP=3, CTRL=EN|RELOAD|IRQEN
    store(CMP_A, 32'd3);
    check_rd("cmp_rd", CMP_A, 32'd3);
    store(CTRL_A, 32'h7);
    for (int k = 0; k < 6; k++) begin
      check_rd($sformatf("per_count_%0d", k), CNT_A, k % 4);
      check_irq($sformatf("per_irq_%0d", k), k >= 4);
      step();
    end
    // now in cycle k=6 (COUNT=2); W1C outside a match cycle
    store(STAT_A, 32'h1);
    check_rd("w1c_count", CNT_A, 32'd3);
    check_irq("w1c_irq_clear", 1'b0);
    step();
    check_irq("irq_reassert", 1'b1);
    step(); step(); step();
    check_rd("match_cycle_count", CNT_A, 32'd3);
    store(STAT_A, 32'h1);
    check_irq("w1c_vs_set_irq", 1'b1);
    check_rd("w1c_vs_set_stat", STAT_A, 32'h1);
    check_rd("reload_count", CNT_A, 32'd0);

    // One-shot
    store(CTRL_A, 32'h0);
    store(STAT_A, 32'h1);
    check_irq("stop_irq", 1'b0);
    store(CNT_A, 32'd0);
    store(CMP_A, 32'd2);
    store(CTRL_A, 32'h5);
    step(); step(); step(); step();
    check_rd("oneshot_count", CNT_A, 32'd2);
    check_rd("oneshot_ctrl", CTRL_A, 32'h4);
    check_irq("oneshot_irq", 1'b1);

    // Wrap and write-over-increment
    store(STAT_A, 32'h1);
    store(CNT_A, 32'hFFFF_FFFF);
    store(CMP_A, 32'd5);
    store(CTRL_A, 32'h1);
    check_rd("wrap_pre", CNT_A, 32'hFFFF_FFFF);
    step();
    check_rd("wrap_post", CNT_A, 32'h0);
    store(CNT_A, 32'd7);
    check_rd("override", CNT_A, 32'd7);
    step();
    check_rd("override_inc", CNT_A, 32'd8);

    // Running periodic timer with irq high, then reset
    store(CTRL_A, 32'h7);
    store(CNT_A, 32'd4);
    step(); step();
    check_irq("pre_reset_irq", 1'b1);
`else
    store(CTRL_A, 32'h7);
    store(CNT_A, 32'd9);
    store(CMP_A, 32'd9);
    store(STAT_A, 32'h1);
    check_rd("notmr_ctrl", CTRL_A, 32'h0);
    check_rd("notmr_count", CNT_A, 32'h0);
    check_rd("notmr_cmp", CMP_A, 32'h0);
    check_rd("notmr_stat", STAT_A, 32'h0);
    check_irq("notmr_irq", 1'b0);
    check_gpio("notmr_gpio", 32'h0000_00A5);
`endif

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_irq("mid_rst_irq", 1'b0);
    check_gpio("mid_rst_gpio", 32'h0);
    check_rd("mid_rst_gpio_rd", GPIO_A, 32'h0);
    check_rd("mid_rst_ctrl", CTRL_A, 32'h0);
    check_rd("mid_rst_count", CNT_A, 32'h0);
    step();
    check_rd("mid_rst_cmp", CMP_A, 32'h0);
    check_rd("mid_rst_stat", STAT_A, 32'h0);
    check_rd("mid_rst_count2", CNT_A, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
